// File: rtl/pixel_histogram.sv
// Per-frame pixel histogram: bins active pixels into saturating RAM counters, then dumps and clears them.
// Latency: 3-cycle read-modify-write per pixel, 1 pixel/cycle; first dump word 1 cycle after DUMP entry.
// Backpressure: pixel input never stalls; the dump holds every hist_* output while hist_ready_i is low.
//
// Ports:
//   clk_i, reset_n_i       pixel clock, synchronous active-low reset
//   enable_i               allows a new frame to start from IDLE
//   pix_data_i, fv_i, lv_i parallel pixel stream; a pixel counts when fv_i & lv_i in ACCUM
//   hist_*                 valid/ready histogram dump (bin index, count, last flag)
//   frame_id_o             completed frames (wraps), drop_count_o dropped frames (saturates)
//   sat_o                  a bin saturated in the frame being dumped, busy_o high outside IDLE
module pixel_histogram #(
    parameter int PIX_W    = 10,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 24,
    parameter int FID_W    = 16
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                enable_i,
    input  logic [PIX_W-1:0]    pix_data_i,
    input  logic                fv_i,
    input  logic                lv_i,
    output logic [CNT_W-1:0]    hist_data_o,
    output logic [BIN_BITS-1:0] hist_bin_o,
    output logic                hist_valid_o,
    output logic                hist_last_o,
    input  logic                hist_ready_i,
    output logic [FID_W-1:0]    frame_id_o,
    output logic [7:0]          drop_count_o,
    output logic                sat_o,
    output logic                busy_o
);

    localparam int                  NBINS    = 1 << BIN_BITS;
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [BIN_BITS-1:0] BIN_LAST = '1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DUMP
    } state_t;

    state_t state;

    // Bin storage: one write port, one synchronous read port (read-before-write).
    logic [CNT_W-1:0]    mem [NBINS];
    logic [CNT_W-1:0]    rd_q;
    logic [BIN_BITS-1:0] rd_addr;
    logic                wr_en;
    logic [BIN_BITS-1:0] wr_addr;
    logic [CNT_W-1:0]    wr_data;

    logic                fv_prev;
    logic                fv_rise;
    logic                fv_fall;
    logic [BIN_BITS-1:0] clr_addr;
    logic [1:0]          flush_cnt;
    logic [BIN_BITS-1:0] dump_addr;

    // Accumulate pipeline: S0 bin register, S1 RAM read, S2 increment + write.
    logic                s0_vld;
    logic [BIN_BITS-1:0] s0_bin;
    logic                s1_vld;
    logic [BIN_BITS-1:0] s1_bin;
    logic                fwd_vld;
    logic [CNT_W-1:0]    fwd_cnt;
    logic [CNT_W-1:0]    cur_cnt;
    logic [CNT_W-1:0]    inc_cnt;

    logic                dump_accept;
    logic                dump_load;

    // Low pixel bits below the bin index are intentionally ignored.
    logic                unused_pix_bits;
    assign unused_pix_bits = ^pix_data_i;

    assign fv_rise = fv_i & ~fv_prev;
    assign fv_fall = ~fv_i & fv_prev;

    // The RAM read of a pixel happens on the same edge as the write of the
    // pixel just ahead of it; that one collision is captured in fwd_cnt.
    // Any older write has already landed before the read, so no other bypass.
    assign cur_cnt = fwd_vld ? fwd_cnt : rd_q;
    assign inc_cnt = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + CNT_W'(1);

    assign dump_accept = (state == S_DUMP) & hist_valid_o & hist_ready_i;
    // Load the next word when the output slot is empty or being drained,
    // except once the last bin is showing.
    assign dump_load   = (state == S_DUMP) & (~hist_valid_o | (hist_ready_i & ~hist_last_o));

    // While stalled in DUMP the read port re-reads the displayed bin, which
    // is not written until accepted, so hist_data_o stays stable.
    always_comb begin
        rd_addr = s0_bin;
        if (state == S_DUMP) begin
            rd_addr = dump_load ? dump_addr : hist_bin_o;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_bin;
        wr_data = inc_cnt;
        case (state)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = '0;
            end
            S_DUMP: begin
                wr_en   = dump_accept;
                wr_addr = hist_bin_o;
                wr_data = '0;
            end
            default: begin
                wr_en = s1_vld;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    assign hist_data_o = hist_valid_o ? rd_q : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state        <= S_CLEAR;
            clr_addr     <= '0;
            flush_cnt    <= '0;
            dump_addr    <= '0;
            fv_prev      <= 1'b0;
            s0_vld       <= 1'b0;
            s0_bin       <= '0;
            s1_vld       <= 1'b0;
            s1_bin       <= '0;
            fwd_vld      <= 1'b0;
            fwd_cnt      <= '0;
            hist_bin_o   <= '0;
            hist_valid_o <= 1'b0;
            hist_last_o  <= 1'b0;
            frame_id_o   <= '0;
            drop_count_o <= '0;
            sat_o        <= 1'b0;
            busy_o       <= 1'b1;
        end else begin
            fv_prev <= fv_i;

            s0_vld  <= (state == S_ACCUM) & fv_i & lv_i;
            s0_bin  <= pix_data_i[PIX_W-1 -: BIN_BITS];
            s1_vld  <= s0_vld;
            s1_bin  <= s0_bin;
            fwd_vld <= s0_vld & s1_vld & (s0_bin == s1_bin);
            fwd_cnt <= inc_cnt;

            if (s1_vld && (cur_cnt == CNT_MAX)) begin
                sat_o <= 1'b1;
            end

            // A frame starting while we cannot accept it is lost.
            if (fv_rise && ((state == S_CLEAR) || (state == S_FLUSH) || (state == S_DUMP))
                && (drop_count_o != 8'hFF)) begin
                drop_count_o <= drop_count_o + 1'b1;
            end

            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == BIN_LAST) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (fv_rise && enable_i) begin
                        state  <= S_ACCUM;
                        busy_o <= 1'b1;
                        sat_o  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (fv_fall) begin
                        state      <= S_FLUSH;
                        flush_cnt  <= '0;
                        frame_id_o <= frame_id_o + 1'b1;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == 2'd2) begin
                        state     <= S_DUMP;
                        dump_addr <= '0;
                    end
                end
                S_DUMP: begin
                    if (dump_accept && hist_last_o) begin
                        hist_valid_o <= 1'b0;
                        hist_last_o  <= 1'b0;
                        hist_bin_o   <= '0;
                        state        <= S_IDLE;
                        busy_o       <= 1'b0;
                    end else if (dump_load) begin
                        hist_valid_o <= 1'b1;
                        hist_bin_o   <= dump_addr;
                        hist_last_o  <= (dump_addr == BIN_LAST);
                        dump_addr    <= dump_addr + 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_histogram.md
Name: pixel_histogram

Overview:
Parametrised per-frame pixel histogram engine. Sits downstream of mipidphy2cmos and consumes the parallel pixel stream (data, fv, lv) in the pixel clock domain. It bins every active pixel of a frame into 2^BIN_BITS saturating counters held in block RAM. After frame end it streams the finished histogram out on a valid/ready interface and clears each bin as that bin is read.

Parameters:
PIX_W, 10, pixel data width in bits
BIN_BITS, 8, log2 of bin count; bin index = pix_data_i[PIX_W-1 -: BIN_BITS]; requires BIN_BITS <= PIX_W
CNT_W, 24, width of each bin counter
FID_W, 16, frame counter width

Ports:
clk_i  in  1  pixel clock
reset_n_i  in  1  synchronous active-low reset
enable_i  in  1  permits start of a new frame
pix_data_i  in  PIX_W  pixel data
fv_i  in  1  frame valid
lv_i  in  1  line valid; a pixel counts when fv_i & lv_i in ACCUM
hist_data_o  out  CNT_W  bin count
hist_bin_o  out  BIN_BITS  bin index of hist_data_o
hist_valid_o  out  1  output word valid
hist_last_o  out  1  marks the final bin (all ones)
hist_ready_i  in  1  downstream accept
frame_id_o  out  FID_W  count of completed frames; wraps
drop_count_o  out  8  frames dropped; saturates at 255
sat_o  out  1  a bin saturated in the frame being dumped
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n_i=0 at a clk_i edge): state=CLEAR, bin address=0. All outputs are 0 except busy_o=1. Reset asserted mid-operation aborts that operation with the same result.
- CLEAR: writes 0 to one bin per cycle, 2^BIN_BITS cycles, then IDLE.
- IDLE: detects a rising edge of fv_i (registered fv_prev=0, fv_i=1).
  - With enable_i=1: go to ACCUM and clear sat_o.
  - With enable_i=0: ignore the edge.
  - If fv_i is already high on entry to IDLE, wait for the next rising edge. Partial frames are never counted.
- ACCUM: runs a 3-stage read-modify-write pipeline:
  - S0 registers the bin index and valid.
  - S1 does a synchronous RAM read.
  - S2 writes min(count+1, 2^CNT_W-1).
  - Forwarding from S2 (and from the pending write) to S1 is mandatory, so consecutive or alternating same-bin pixels count exactly. One pixel per cycle, no stalls.
  - Incrementing a bin already at max sets sat_o=1.
  - enable_i going low in ACCUM has no effect; the frame completes.
- Falling edge of fv_i in ACCUM: go to FLUSH and increment frame_id_o by 1.
- FLUSH: 3 cycles to drain the pipeline, then DUMP.
- DUMP: reads bins 0..2^BIN_BITS-1 in order.
  - hist_valid_o is asserted with hist_bin_o and hist_data_o.
  - While hist_valid_o=1 and hist_ready_i=0, all hist_* outputs hold stable.
  - On accept, write 0 to that bin and present the next bin; a prefetched read allows 1 word/cycle under continuous ready.
  - hist_last_o=1 only with bin 2^BIN_BITS-1.
  - Accept of the last bin: hist_valid_o=0 next cycle, state=IDLE.
  - The first word appears no earlier than 1 cycle after DUMP entry.
- Drop: a rising edge of fv_i seen in CLEAR, FLUSH or DUMP increments drop_count_o (saturating at 255). A rising edge in IDLE with enable_i=0 is not a drop. The dropped frame is not counted.
- frame_id_o and drop_count_o reset to 0. They are stable except at their update edges.

Test Plan:
1. Release reset -> busy_o=1 for exactly 256 cycles, then 0. hist_valid_o stays 0. All counters read 0 in the first dump.
2. One frame, 4 lines x 8 pixels of 0x3FF, hist_ready_i=1 -> 256 beats; bin 255=32 with hist_last_o=1; all other bins 0; frame_id_o=1; sat_o=0.
3. Forwarding: 100 consecutive pixels of 0x004, then 50 alternating 0x008/0x00C -> bin1=100, bin2=25, bin3=25, others 0.
4. Backpressure: hist_ready_i high 1 cycle in 3 -> exactly 256 accepted beats in order; data held stable while stalled; an identical second frame produces identical counts (no residue).
5. fv_i rises during DUMP -> drop_count_o=1 and that frame is not counted. The next frame, started in IDLE, dumps correctly with frame_id_o=2.
6. CNT_W=4: 20 pixels into bin 7 -> bin 7=15, sat_o=1. Reset asserted mid-ACCUM -> 256-cycle CLEAR, then a fresh frame counts from 0 with frame_id_o=1 after it completes.
